// File: rtl/udp_tx_pkg.sv
// Shared types and defaults for the UDP transmit arbiter.
// Both the top and the round-robin picker import this package.
package udp_tx_pkg;

   localparam int N_SRC_DEF     = 4;
   localparam int MAX_WORDS_DEF = 375;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } tx_state_e;

   // Width of a source index; never zero so one-source builds still elaborate.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant,
// wrapping from N_SRC-1 back to 0.
module rr_arbiter
   import udp_tx_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF
)(
   input  logic [N_SRC-1:0]        req,
   input  logic [idx_w(N_SRC)-1:0] last_grant,
   output logic [idx_w(N_SRC)-1:0] gnt_idx,
   output logic                    gnt_valid
);

   localparam int IW = idx_w(N_SRC);

   int            c;
   logic [IW-1:0] idx;

   // Walk from the farthest offset to the nearest so the nearest requester
   // is the last one written and therefore wins.
   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      c         = 0;
      idx       = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         c   = (int'(last_grant) + k) % N_SRC;
         idx = IW'(c);
         if (req[idx]) begin
            gnt_idx   = idx;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-locked round-robin mux of N_SRC AXI-Stream sources onto one port,
// truncating packets longer than MAX_WORDS and draining the remainder.
module udp_tx_arbiter
   import udp_tx_pkg::*;
#(
   parameter int N_SRC     = N_SRC_DEF,
   parameter int MAX_WORDS = MAX_WORDS_DEF
)(
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [N_SRC-1:0][31:0]  s_axis_tdata,
   input  logic [N_SRC-1:0]        s_axis_tvalid,
   input  logic [N_SRC-1:0]        s_axis_tlast,
   output logic [N_SRC-1:0]        s_axis_tready,
   output logic [31:0]             m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   output logic [idx_w(N_SRC)-1:0] m_axis_tid,
   input  logic                    m_axis_tready,
   output logic                    busy,
   output logic                    trunc_err
);

   localparam int IW = idx_w(N_SRC);
   localparam int CW = $clog2(MAX_WORDS + 1);

   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS - 1);
   localparam logic [IW-1:0] LG_RST   = IW'(N_SRC - 1);

   tx_state_e     state;
   tx_state_e     state_n;
   logic [IW-1:0] grant;
   logic [IW-1:0] grant_n;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] last_grant_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          trunc_n;

   logic [IW-1:0] rr_idx;
   logic          rr_valid;

   logic          src_valid;
   logic          src_last;
   logic          at_limit;
   logic          beat;

   rr_arbiter #(
      .N_SRC (N_SRC)
   ) u_rr (
      .req        (s_axis_tvalid),
      .last_grant (last_grant),
      .gnt_idx    (rr_idx),
      .gnt_valid  (rr_valid)
   );

   assign src_valid = s_axis_tvalid[grant];
   assign src_last  = s_axis_tlast[grant];
   assign at_limit  = (cnt == LAST_CNT);
   assign beat      = src_valid & m_axis_tready;

   assign m_axis_tdata = s_axis_tdata[grant];
   assign m_axis_tid   = grant;
   assign busy         = (state != IDLE);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= LG_RST;
         cnt        <= '0;
         trunc_err  <= 1'b0;
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         last_grant <= last_grant_n;
         cnt        <= cnt_n;
         trunc_err  <= trunc_n;
      end
   end

   always_comb begin
      state_n       = state;
      grant_n       = grant;
      last_grant_n  = last_grant;
      cnt_n         = cnt;
      trunc_n       = 1'b0;
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;

      unique case (state)
         IDLE: begin
            if (rr_valid) begin
               grant_n = rr_idx;
               cnt_n   = '0;
               state_n = XFER;
            end
         end

         XFER: begin
            m_axis_tvalid        = src_valid;
            m_axis_tlast         = src_last | at_limit;
            s_axis_tready[grant] = m_axis_tready;
            if (beat) begin
               cnt_n = cnt + CW'(1);
               // A real tlast on the limit word is a normal end of packet.
               if (src_last) begin
                  last_grant_n = grant;
                  state_n      = IDLE;
               end else if (at_limit) begin
                  trunc_n = 1'b1;
                  state_n = DRAIN;
               end
            end
         end

         DRAIN: begin
            s_axis_tready[grant] = 1'b1;
            if (src_valid && src_last) begin
               last_grant_n = grant;
               state_n      = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed and randomized bench for udp_tx_arbiter; a behavioural model
// of grant ownership and beat counts is compared every cycle.
module tb_udp_tx_arbiter;

   localparam int N    = 4;
   localparam int MAXW = 375;

   logic               aclk     = 1'b0;
   logic               aresetn  = 1'b0;
   logic [N-1:0][31:0] s_tdata  = '0;
   logic [N-1:0]       s_tvalid = '0;
   logic [N-1:0]       s_tlast  = '0;
   logic [N-1:0]       s_tready;
   logic [31:0]        m_tdata;
   logic               m_tvalid;
   logic               m_tlast;
   logic [1:0]         m_tid;
   logic               m_tready = 1'b1;
   logic               busy;
   logic               trunc_err;

   udp_tx_arbiter #(
      .N_SRC     (N),
      .MAX_WORDS (MAXW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .m_axis_tready (m_tready),
      .busy          (busy),
      .trunc_err     (trunc_err)
   );

   always #5 aclk = ~aclk;

   int tests = 0;
   int fails = 0;

   // Source drivers: a queue of packet lengths per source.
   int       plen[N][$];
   int       pidx[N];
   int       widx[N];
   bit [N-1:0] hs;
   bit       gap_en = 1'b0;
   int       rmode  = 0;

   // Reference model state.
   int m_owner = -1;
   int m_sent  = 0;
   int m_last  = N - 1;
   bit m_drop  = 1'b0;
   bit m_tpend = 1'b0;
   bit m_on    = 1'b0;

   // Observations of the DUT output stream.
   int cyc     = 0;
   int ndrop   = 0;
   int ntr_dut = 0;
   int obeats  = 0;
   int oq[$];
   int olen[$];
   int ofirst[$];
   int oend[$];

   function automatic logic [31:0] pat(input int s, input int p, input int w);
      return {8'(s), 8'(p), 16'(w)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge aclk) begin
      int o;
      cyc++;
      o  = m_owner;
      hs = s_tvalid & s_tready & {N{aresetn}};

      if (aresetn && m_tvalid && m_tready) begin
         if (obeats == 0) ofirst.push_back(cyc);
         obeats++;
         if (m_tlast) begin
            oq.push_back(int'(m_tid));
            olen.push_back(obeats);
            oend.push_back(cyc);
            obeats = 0;
         end
      end
      if (aresetn && trunc_err) ntr_dut++;

      if (m_on) begin
         chk("busy", busy, 64'(m_owner >= 0));
         chk("trunc_err", trunc_err, 64'(m_tpend));
         if (o < 0) begin
            chk("idle_m_tvalid", m_tvalid, 0);
            chk("idle_s_tready", s_tready, 0);
         end else begin
            chk("m_tid", m_tid, o);
            if (m_drop) begin
               chk("drain_m_tvalid", m_tvalid, 0);
               chk("drain_s_tready", s_tready, 64'(1) << o);
            end else begin
               chk("m_tvalid", m_tvalid, 64'(s_tvalid[o]));
               chk("s_tready", s_tready, 64'(m_tready) << o);
               if (s_tvalid[o]) begin
                  chk("m_tdata", m_tdata, pat(o, pidx[o], m_sent));
                  chk("m_tlast", m_tlast,
                      64'(s_tlast[o] || (m_sent == MAXW - 1)));
               end
            end
         end
      end

      m_tpend = 1'b0;
      if (!aresetn) begin
         m_owner = -1;
         m_last  = N - 1;
         m_sent  = 0;
         m_drop  = 1'b0;
         m_on    = 1'b1;
      end else if (m_on) begin
         if (o < 0) begin
            for (int k = 1; k <= N; k++)
               if (m_owner < 0 && s_tvalid[(m_last + k) % N])
                  m_owner = (m_last + k) % N;
            m_sent = 0;
            m_drop = 1'b0;
         end else if (m_drop) begin
            if (s_tvalid[o]) begin
               ndrop++;
               if (s_tlast[o]) begin
                  m_last  = o;
                  m_owner = -1;
               end
            end
         end else if (s_tvalid[o] && m_tready) begin
            m_sent++;
            if (s_tlast[o]) begin
               m_last  = o;
               m_owner = -1;
            end else if (m_sent == MAXW) begin
               m_tpend = 1'b1;
               m_drop  = 1'b1;
            end
         end
      end
   end

   task automatic drive();
      for (int s = 0; s < N; s++) begin
         if (plen[s].size() == 0) begin
            s_tvalid[s] = 1'b0;
            s_tlast[s]  = 1'b0;
         end else begin
            if (!(s_tvalid[s] && !hs[s]))
               s_tvalid[s] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_tdata[s] = pat(s, pidx[s], widx[s]);
            s_tlast[s] = (widx[s] == plen[s][0] - 1);
         end
      end
      case (rmode)
         0:       m_tready = 1'b1;
         1:       m_tready = ($urandom_range(0, 3) != 0);
         default: m_tready = ~m_tready;
      endcase
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
      for (int s = 0; s < N; s++) begin
         if (hs[s] && plen[s].size() > 0) begin
            widx[s]++;
            if (widx[s] == plen[s][0]) begin
               void'(plen[s].pop_front());
               pidx[s]++;
               widx[s] = 0;
            end
         end
      end
      drive();
   endtask

   task automatic clear_src();
      for (int s = 0; s < N; s++) begin
         plen[s].delete();
         widx[s] = 0;
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      gap_en  = 1'b0;
      rmode   = 0;
      clear_src();
      drive();
      tick();
      tick();
      aresetn = 1'b1;
      oq.delete();
      olen.delete();
      ofirst.delete();
      oend.delete();
      ndrop   = 0;
      ntr_dut = 0;
      obeats  = 0;
   endtask

   task automatic run(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         done = (m_owner < 0);
         for (int s = 0; s < N; s++)
            if (plen[s].size() != 0) done = 1'b0;
      end
      chk("finish_in_budget", 64'(done), 1);
      tick();
      tick();
   endtask

   initial begin
      int total;
      int lim;

      for (int s = 0; s < N; s++) begin
         pidx[s] = 0;
         widx[s] = 0;
      end

      do_reset();
      @(negedge aclk);
      chk("rst_busy", busy, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_trunc_err", trunc_err, 0);
      chk("rst_m_tid", m_tid, 0);

      // Sources 0 and 2 together: 0 first, one bubble, then 2.
      plen[0].push_back(3);
      plen[2].push_back(3);
      run(100);
      chk("s02_count", oq.size(), 2);
      chk("s02_first", oq[0], 0);
      chk("s02_second", oq[1], 2);
      chk("s02_len0", olen[0], 3);
      chk("s02_len1", olen[1], 3);
      chk("s02_bubble", ofirst[1] - oend[0], 2);

      // All four sources busy: 0,1,2,3,0 with a bubble between each.
      do_reset();
      plen[0].push_back(2);
      plen[0].push_back(2);
      for (int s = 1; s < N; s++) plen[s].push_back(2);
      run(200);
      chk("rr_count", oq.size(), 5);
      for (int i = 0; i < 5; i++) chk("rr_order", oq[i], i % N);
      for (int i = 0; i < 4; i++)
         chk("rr_bubble", ofirst[i + 1] - oend[i], 2);

      // Oversize packet: cut at MAXW, rest drained.
      do_reset();
      plen[1].push_back(400);
      run(1200);
      chk("trunc_tid", oq[0], 1);
      chk("trunc_len", olen[0], MAXW);
      chk("trunc_pulses", ntr_dut, 1);
      chk("trunc_drained", ndrop, 25);

      // Exactly MAXW words with a real tlast is not a truncation.
      do_reset();
      plen[3].push_back(MAXW);
      run(1200);
      chk("exact_tid", oq[0], 3);
      chk("exact_len", olen[0], MAXW);
      chk("exact_pulses", ntr_dut, 0);
      chk("exact_drained", ndrop, 0);

      // Toggling downstream ready.
      do_reset();
      rmode = 2;
      plen[1].push_back(4);
      run(100);
      chk("tog_count", oq.size(), 1);
      chk("tog_tid", oq[0], 1);
      chk("tog_len", olen[0], 4);

      // Reset during word 2 of a 5-word packet.
      do_reset();
      plen[2].push_back(5);
      lim = 0;
      while (widx[2] != 1 && lim < 50) begin
         tick();
         lim++;
      end
      chk("mid_reach_word2", widx[2], 1);
      aresetn = 1'b0;
      tick();
      clear_src();
      aresetn = 1'b1;
      drive();
      @(negedge aclk);
      chk("mid_rel_tvalid", m_tvalid, 0);
      chk("mid_rel_busy", busy, 0);
      chk("mid_rel_tid", m_tid, 0);
      oq.delete();
      olen.delete();
      plen[3].push_back(2);
      plen[0].push_back(2);
      run(100);
      chk("mid_count", oq.size(), 2);
      chk("mid_next_first", oq[0], 0);
      chk("mid_next_second", oq[1], 3);

      // Randomized traffic with gaps and random backpressure.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         gap_en = 1'b1;
         rmode  = 1;
         total  = 0;
         for (int s = 0; s < N; s++)
            for (int p = 0; p < 3; p++) begin
               plen[s].push_back($urandom_range(1, 8));
               total += plen[s][p];
            end
         run(3000);
         chk("rand_pkts", oq.size(), 12);
         lim = 0;
         foreach (olen[i]) lim += olen[i];
         chk("rand_words", lim, total);
         chk("rand_no_trunc", ntr_dut, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far",
               fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning number of 32-bit AXI-Stream requesters.
REQ-002 SHALL have parameter MAX_WORDS, default 375, meaning maximum words per packet (1500 bytes / 4).
REQ-003 SHALL have port aclk, input, 1, clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port s_axis_tdata, input, N_SRC x 32, per-source data.
REQ-006 SHALL have port s_axis_tvalid, input, N_SRC, per-source valid.
REQ-007 SHALL have port s_axis_tlast, input, N_SRC, per-source end-of-packet.
REQ-008 SHALL have port s_axis_tready, output, N_SRC, per-source ready.
REQ-009 SHALL have port m_axis_tdata, output, 32, muxed data.
REQ-010 SHALL have port m_axis_tvalid, output, 1, muxed valid.
REQ-011 SHALL have port m_axis_tlast, output, 1, muxed or forced end-of-packet.
REQ-012 SHALL have port m_axis_tid, output, clog2(N_SRC), granted source index.
REQ-013 SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port trunc_err, output, 1, one-cycle pulse when a packet is truncated.

Function
REQ-016 SHALL implement FSM states IDLE, XFER and DRAIN.
REQ-017 In IDLE, when any s_axis_tvalid is high, SHALL register grant as the first requesting index after last_grant (round-robin, wrapping N_SRC-1 to 0) and go to XFER next cycle; arbitration latency is one cycle.
REQ-018 In IDLE, SHALL hold all s_axis_tready low and m_axis_tvalid low.
REQ-019 In XFER, m_axis_tdata/tvalid/tlast SHALL combinationally equal the granted source's signals, and s_axis_tready[grant] SHALL equal m_axis_tready; all other readys stay low.
REQ-020 m_axis_tid SHALL equal grant throughout XFER.
REQ-021 Word counter SHALL clear on entering XFER and increment on each m_axis handshake.
REQ-022 On a handshake with tlast in XFER, SHALL set last_grant to grant and return to IDLE.
REQ-023 Grant SHALL be packet-locked: no re-arbitration until tlast or truncation, whatever other requests arrive.
REQ-024 When the handshake is word MAX_WORDS without source tlast, SHALL force m_axis_tlast high on that beat, pulse trunc_err, and go to DRAIN.
REQ-025 If source tlast and the MAX_WORDS limit coincide, SHALL treat the beat as normal end-of-packet: no trunc_err, no DRAIN.
REQ-026 In DRAIN, SHALL drive s_axis_tready[grant] high and m_axis_tvalid low, discard beats until the granted source's tlast handshake, then set last_grant to grant and go to IDLE.
REQ-027 A new request arriving in the same cycle as an end-of-packet SHALL be arbitrated only in the following IDLE cycle; one bubble between packets is mandatory.
REQ-028 Source tvalid deasserting mid-packet SHALL keep the grant and stall output with m_axis_tvalid low.

Reset
REQ-029 While aresetn is low, SHALL clear state to IDLE, grant to 0, last_grant to N_SRC-1 (source 0 wins first), counter to 0, trunc_err to 0, and busy to 0.
REQ-030 Reset mid-packet SHALL abandon the packet with no forced tlast; outputs SHALL be idle on the first cycle after release.

Structure
REQ-031 Package udp_tx_pkg SHALL hold the FSM state typedef and the defaults for N_SRC and MAX_WORDS.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_arbiter with inputs req and last_grant and outputs gnt_idx and gnt_valid.

Verification
REQ-033 Source 0 and source 2 request together after reset, each with a 3-word packet -> source 0 first (tid=0), then one bubble, then source 2 (tid=2).
REQ-034 All four sources request continuously with 2-word packets -> grant order 0,1,2,3,0, no interleaving.
REQ-035 Source 1 sends 400 words with tlast on word 400 -> word 375 carries m_axis_tlast=1 and trunc_err pulses once; words 376-400 are consumed with m_axis_tvalid=0; then IDLE.
REQ-036 Source 3 sends exactly 375 words with tlast on word 375 -> no trunc_err, normal return to IDLE.
REQ-037 m_axis_tready toggles 1,0,1,0 during a 4-word packet from source 1 -> data order preserved, s_axis_tready[1] mirrors m_axis_tready, other readys stay 0.
REQ-038 aresetn is pulsed low on word 2 of a 5-word packet -> the cycle after release has tvalid=0, busy=0, and the next grant goes to source 0.
